// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and table sizing.
`ifndef BRANCH_PREDICTOR_PKG_SV
`define BRANCH_PREDICTOR_PKG_SV
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int DEFAULT_ENTRIES = 16;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

endpackage
`endif

// File: rtl/sat_counter_2b.sv
// 2-bit saturating counter next-state: one step toward ST on taken, toward SNT on not-taken.
module sat_counter_2b
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    next_state = state;
    if (taken && state != ST)
      next_state = state + 2'd1;
    else if (!taken && state != SNT)
      next_state = state - 2'd1;
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational lookup, single update port from EX.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] fetch_pc,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_target,
  output logic            predict_hit,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0]                vld;
  logic [ENTRIES-1:0][1:0]           ctr;
  logic [ENTRIES-1:0][TAG_W-1:0]     tag;
  logic [ENTRIES-1:0][XLEN-1:0]      tgt;

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit;
  logic [1:0]       ctr_nxt;

  // Byte offset within the instruction word never participates.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[XLEN-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[XLEN-1:IDX_W+2];

  // Lookup: reads current register contents, so a same-cycle update is seen next cycle.
  assign predict_hit    = vld[f_idx] && (tag[f_idx] == f_tag);
  assign predict_taken  = predict_hit && ctr[f_idx][1];
  assign predict_target = predict_taken ? tgt[f_idx] : fetch_pc + XLEN'(4);

  assign u_hit = vld[u_idx] && (tag[u_idx] == u_tag);

  sat_counter_2b u_ctr (
    .state      (ctr[u_idx]),
    .taken      (upd_taken),
    .next_state (ctr_nxt)
  );

  // Valid and counter state: cleared asynchronously, so reset also kills any pending update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr[i] <= WNT;
    end else if (upd_valid) begin
      if (u_hit) begin
        ctr[u_idx] <= ctr_nxt;
      end else begin
        vld[u_idx] <= 1'b1;
        ctr[u_idx] <= upd_taken ? WT : WNT;
      end
    end
  end

  // Tag/target payload; contents are don't-care while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (upd_valid) begin
      if (!u_hit) begin
        tag[u_idx] <= u_tag;
        tgt[u_idx] <= upd_target;
      end else if (upd_taken) begin
        tgt[u_idx] <= upd_target;
      end
    end
  end

endmodule
